// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit and its queue.
// Holds the FSM encoding, queue geometry and the reset fetch address.
package fetch_unit_pkg;

   localparam int unsigned QUEUE_DEPTH = 2;
   localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);

   localparam logic [31:0]      RESET_PC   = 32'h0000_0000;
   localparam logic [CNT_W-1:0] QUEUE_FULL = CNT_W'(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_entry_t;

   // Redirect targets are word aligned; the low two bits are simply dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order instruction queue between fetch and decode.
// Flush wins over push and pop; the head is presented combinationally.
module fetch_queue
   import fetch_unit_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     data,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     entries [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != QUEUE_FULL) || do_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the storage is reset too, because the head drives id_instr/id_pc4,
         // which must read zero while reset is held.
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entries[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            entries[wr_ptr] <= data;
            wr_ptr          <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, a two-entry queue to decode,
// and redirect handling that discards in-flight responses.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   fetch_state_t     state;
   logic [31:0]      fetch_pc;
   logic [31:0]      next_addr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after;
   logic             push;
   logic             pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   assign next_addr   = imem_addr + 32'd4;
   assign push        = (state == S_WAIT) && imem_ack && !redirect;
   assign pop         = id_valid && id_ready;
   assign push_entry  = '{instr: imem_rdata, pc4: next_addr};
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);

   fetch_queue u_queue (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .data  (push_entry),
      .count (count),
      .head  (head)
   );

   assign id_valid = (count != '0);
   assign id_instr = head.instr;
   assign id_pc4   = head.pc4;

   // NOTE: state, fetch_pc and the memory-side outputs all live in this one clocked
   // block with non-blocking assignments, so imem_req/imem_addr are true registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect) begin
                  fetch_pc <= align_pc(redirect_pc);
               end else if (count < QUEUE_FULL) begin
                  imem_addr <= fetch_pc;
                  imem_req  <= 1'b1;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect) begin
                  fetch_pc <= align_pc(redirect_pc);
                  if (imem_ack) begin
                     imem_req <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     state <= S_DROP;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= next_addr;
                  // Keep streaming while the queue still has room after this edge.
                  if (count_after < QUEUE_FULL) begin
                     imem_addr <= next_addr;
                  end else begin
                     imem_req <= 1'b0;
                     state    <= S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (redirect) begin
                  fetch_pc <= align_pc(redirect_pc);
               end
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-controlled memory model plus a
// stream-level reference (expected delivered PC, expected next request address).
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   // Reference state: what decode should see next, and where the next fetch must go.
   logic [31:0] expected_pc;
   logic [31:0] next_req_addr;
   logic [31:0] req_addr;
   bit          busy;
   bit          killed;
   bit          flush_pending;
   int          lat;
   int          wait_cnt;
   int          fixed_lat;
   int          max_lat;
   bit          spurious_en;

   fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .id_ready    (id_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      expected_pc   = 32'h0;
      next_req_addr = 32'h0;
      busy          = 1'b0;
      killed        = 1'b0;
      flush_pending = 1'b0;
   endtask

   // Sample at the falling edge, play the memory side, and check the decode head.
   task automatic tick();
      @(negedge clock);
      if (imem_req) begin
         if (!busy) begin
            check("req_addr", imem_addr, next_req_addr);
            busy     = 1'b1;
            killed   = 1'b0;
            req_addr = imem_addr;
            wait_cnt = 0;
            lat      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat, 0));
         end else begin
            check("addr_hold", imem_addr, req_addr);
         end
         wait_cnt++;
         if (lat == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(req_addr);
         end else begin
            lat--;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
         end
      end else begin
         if (busy) check("req_dropped", imem_req, 1);
         busy       = 1'b0;
         imem_ack   = spurious_en && ($urandom_range(3, 0) == 0);
         imem_rdata = $urandom;
      end
      if (flush_pending) check("flush_valid", id_valid, 0);
      if (id_valid) begin
         check("head_instr", id_instr, mem_word(expected_pc));
         check("head_pc4", id_pc4, expected_pc + 32'd4);
      end
   endtask

   // Apply decode-side inputs for the coming edge and advance the reference.
   task automatic drive(input bit rdy, input bit redir, input logic [31:0] tgt);
      id_ready      = rdy;
      redirect      = redir;
      redirect_pc   = tgt;
      flush_pending = redir;
      if (redir) begin
         expected_pc   = {tgt[31:2], 2'b00};
         next_req_addr = expected_pc;
         killed        = busy;
      end else if (id_valid && rdy) begin
         expected_pc = expected_pc + 32'd4;
      end
      if (busy && imem_ack) begin
         if (!redir && !killed) next_req_addr = req_addr + 32'd4;
         busy = 1'b0;
      end
   endtask

   initial begin
      bit          found;
      bit          rdy;
      bit          redir;
      logic [31:0] tgt;

      reset       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      fixed_lat   = 0;
      max_lat     = 0;
      spurious_en = 1'b0;
      model_reset();

      // Power-on reset with ack pulses that must be ignored.
      repeat (2) @(negedge clock);
      imem_ack = 1'b1;
      #1;
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_valid", id_valid, 0);
      check("rst_instr", id_instr, 0);
      check("rst_pc4", id_pc4, 0);
      @(negedge clock);
      imem_ack = 1'b0;
      reset    = 1'b1;
      id_ready = 1'b1;
      model_reset();

      // Zero-wait streaming: valid two edges after release, then one per cycle.
      tick();
      check("edge1_valid", id_valid, 0);
      check("edge1_req", imem_req, 1);
      drive(1, 0, 32'h0);
      tick();
      check("edge2_valid", id_valid, 1);
      check("edge2_pc4", id_pc4, 32'h4);
      drive(1, 0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("rate_valid", id_valid, 1);
         check("rate_req", imem_req, 1);
         drive(1, 0, 32'h0);
      end

      // Reset asserted mid-request, memory acks during reset.
      tick();
      check("pre_reset_req", imem_req, 1);
      drive(0, 0, 32'h0);
      #2 reset = 1'b0;
      #1;
      check("arst_req", imem_req, 0);
      check("arst_addr", imem_addr, 0);
      check("arst_valid", id_valid, 0);
      check("arst_instr", id_instr, 0);
      check("arst_pc4", id_pc4, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         imem_ack   = (i % 2 == 0);
         imem_rdata = $urandom;
         check("inrst_req", imem_req, 0);
         check("inrst_valid", id_valid, 0);
      end
      @(negedge clock);
      imem_ack = 1'b0;
      reset    = 1'b1;
      model_reset();

      // Decode stall: queue fills, requests stop, head holds the first word.
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(0, 0, 32'h0);
      end
      tick();
      check("stall_req", imem_req, 0);
      check("stall_valid", id_valid, 1);
      check("stall_pc4", id_pc4, 32'h4);
      check("stall_instr", id_instr, mem_word(32'h0));
      drive(1, 0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(1, 0, 32'h0);
      end

      // Slow memory, redirect while the request is in its second wait cycle.
      fixed_lat = 2;
      found     = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (busy && wait_cnt == 2 && !imem_ack) begin
            found = 1'b1;
            drive(1, 1, 32'h40);
         end else begin
            drive(1, 0, 32'h0);
         end
      end
      check("wait2_reached", found, 1);
      tick();
      check("drop_req", imem_req, 1);
      drive(1, 0, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (id_valid) begin
            found = 1'b1;
            check("redir_first_pc4", id_pc4, 32'h44);
         end
         drive(1, 0, 32'h0);
      end
      check("redir_valid_seen", found, 1);

      // Redirect coincident with an acknowledge: data discarded, refetch at 0x100.
      fixed_lat = 0;
      found     = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (busy && imem_ack) begin
            found = 1'b1;
            drive(1, 1, 32'h103);
         end else begin
            drive(1, 0, 32'h0);
         end
      end
      check("ack_redir_hit", found, 1);
      tick();
      check("ackr_valid", id_valid, 0);
      check("ackr_req", imem_req, 0);
      drive(1, 0, 32'h0);
      tick();
      check("ackr_req2", imem_req, 1);
      check("ackr_addr", imem_addr, 32'h100);
      drive(1, 0, 32'h0);

      // Address wrap at the top of the address space.
      tick();
      drive(1, 1, 32'hFFFF_FFFC);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (id_valid) begin
            found = 1'b1;
            check("wrap_pc4_a", id_pc4, 32'h0);
         end
         drive(1, 0, 32'h0);
      end
      check("wrap_valid_seen", found, 1);
      tick();
      check("wrap_valid_b", id_valid, 1);
      check("wrap_pc4_b", id_pc4, 32'h4);
      drive(1, 0, 32'h0);

      // Randomized traffic: variable latency, stalls, redirects, stray acks.
      spurious_en = 1'b1;
      fixed_lat   = -1;
      for (int seg = 0; seg < 6; seg++) begin
         max_lat = int'($urandom_range(3, 0));
         for (int i = 0; i < 100; i++) begin
            tick();
            rdy   = ($urandom_range(3, 0) != 0);
            redir = ($urandom_range(19, 0) == 0);
            case ($urandom_range(2, 0))
               0:       tgt = $urandom;
               1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
               default: tgt = 32'($urandom_range(255, 0));
            endcase
            drive(rdy, redir, tgt);
         end
      end
      tick();
      drive(0, 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
